// File: rtl/thermal_fb_if.sv
// Sensor write channel into the thermal framebuffer scheduler.
// Signal names follow the scheduler's point of view: i_* flow in, o_* flow out.
interface thermal_fb_if #(
    parameter int unsigned p_addr_width = 10,
    parameter int unsigned p_data_width = 16
);
    logic                    i_wr_valid;
    logic [p_addr_width-1:0] i_wr_addr;
    logic [p_data_width-1:0] i_wr_data;
    logic                    o_wr_ready;

    modport master (output i_wr_valid, i_wr_addr, i_wr_data, input  o_wr_ready);
    modport slave  (input  i_wr_valid, i_wr_addr, i_wr_data, output o_wr_ready);
endinterface

// File: rtl/thermal_fb_scheduler.sv
// Arbitrates the single-port thermal framebuffer between sensor writes and
// per-row-band fetches into a ping-pong line buffer for integer upscaling.
module thermal_fb_scheduler #(
    parameter int unsigned p_src_width   = 32,
    parameter int unsigned p_src_height  = 24,
    parameter int unsigned p_scale       = 20,
    parameter int unsigned p_addr_width  = 10,
    parameter int unsigned p_data_width  = 16,
    parameter int unsigned p_count_width = 16
) (
    input  logic                            i_clk_pixel,
    input  logic                            i_rst,
    input  logic                            i_line,
    input  logic signed [p_count_width-1:0] i_y_pos,
    thermal_fb_if.slave                     wr,
    output logic                            o_mem_en,
    output logic                            o_mem_we,
    output logic [p_addr_width-1:0]         o_mem_addr,
    output logic [p_data_width-1:0]         o_mem_wdata,
    input  logic [p_data_width-1:0]         i_mem_rdata,
    output logic                            o_lb_we,
    output logic [$clog2(p_src_width):0]    o_lb_addr,
    output logic [p_data_width-1:0]         o_lb_wdata,
    output logic                            o_rd_bank,
    output logic                            o_overrun
);
    localparam int unsigned aw     = p_addr_width;
    localparam int unsigned dw     = p_data_width;
    localparam int unsigned cw     = p_count_width;
    localparam int unsigned idx_w  = $clog2(p_src_width);
    localparam int unsigned row_w  = (p_src_height > 1) ? $clog2(p_src_height) : 1;
    localparam int unsigned sub_w  = (p_scale > 1) ? $clog2(p_scale) : 1;
    localparam logic signed [cw-1:0] y_adv_last  = cw'(p_src_height * p_scale - 2);
    localparam logic signed [cw-1:0] y_disp_last = cw'(p_src_height * p_scale - 1);

    typedef enum logic [1:0] {st_idle, st_fetch, st_drain} state_t;

    state_t             state_q, state_d;
    logic [idx_w-1:0]   idx_q, idx_d, idx_nxt;
    logic               pend_q, pend_d;
    logic [row_w-1:0]   row_q, row_d;
    logic [sub_w-1:0]   sub_q, sub_d;
    logic [aw-1:0]      base_q, base_d;
    logic [aw-1:0]      fetch_base_q, fetch_base_d;
    logic               fetch_bank_q, fetch_bank_d;
    logic               mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [aw-1:0]      mem_addr_q, mem_addr_d;
    logic [dw-1:0]      mem_wdata_q, mem_wdata_d;
    logic               lb_we_q, lb_we_d;
    logic [idx_w:0]     lb_addr_q, lb_addr_d;
    logic               rd_bank_q, rd_bank_d;
    logic               overrun_q, overrun_d;
    logic               wr_ready_q, wr_ready_d;
    logic               trig, accept;
    logic               line_first, line_adv, line_disp;

    // Line classification from the signed y position
    assign line_first = i_line && (&i_y_pos);
    assign line_adv   = i_line && !i_y_pos[cw-1] && (i_y_pos <= y_adv_last);
    assign line_disp  = i_line && !i_y_pos[cw-1] && (i_y_pos <= y_disp_last);
    assign idx_nxt    = idx_q + idx_w'(1);

    always_ff @(posedge i_clk_pixel) begin
        if (i_rst) begin
            state_q      <= st_idle;
            idx_q        <= '0;
            pend_q       <= 1'b0;
            row_q        <= '0;
            sub_q        <= '0;
            base_q       <= '0;
            fetch_base_q <= '0;
            fetch_bank_q <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            lb_we_q      <= 1'b0;
            lb_addr_q    <= '0;
            rd_bank_q    <= 1'b0;
            overrun_q    <= 1'b0;
            wr_ready_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            row_q        <= row_d;
            sub_q        <= sub_d;
            base_q       <= base_d;
            fetch_base_q <= fetch_base_d;
            fetch_bank_q <= fetch_bank_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            lb_we_q      <= lb_we_d;
            lb_addr_q    <= lb_addr_d;
            rd_bank_q    <= rd_bank_d;
            overrun_q    <= overrun_d;
            wr_ready_q   <= wr_ready_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        pend_d       = pend_q;
        row_d        = row_q;
        sub_d        = sub_q;
        base_d       = base_q;
        fetch_base_d = fetch_base_q;
        fetch_bank_d = fetch_bank_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        lb_we_d      = (state_q == st_fetch);
        lb_addr_d    = (state_q == st_fetch) ? {fetch_bank_q, idx_q} : lb_addr_q;
        rd_bank_d    = rd_bank_q;
        overrun_d    = overrun_q;
        trig         = 1'b0;
        accept       = wr.i_wr_valid && wr_ready_q;

        // Row band tracking; the base is accumulated so no multiplier is needed
        if (line_first) begin
            row_d  = '0;
            sub_d  = '0;
            base_d = '0;
            trig   = 1'b1;
        end else if (line_adv) begin
            if (sub_q == sub_w'(p_scale - 1)) begin
                sub_d  = '0;
                row_d  = row_q + row_w'(1);
                base_d = base_q + aw'(p_src_width);
                trig   = 1'b1;
            end else begin
                sub_d = sub_q + sub_w'(1);
            end
        end
        if (line_disp) rd_bank_d = row_q[0];

        unique case (state_q)
            st_idle: begin
                if (pend_q || (trig && !accept)) begin
                    if (pend_q && trig) overrun_d = 1'b1;
                    fetch_base_d = pend_q ? fetch_base_q : base_d;
                    fetch_bank_d = pend_q ? fetch_bank_q : row_d[0];
                    state_d      = st_fetch;
                    idx_d        = '0;
                    pend_d       = 1'b0;
                    mem_en_d     = 1'b1;
                    mem_addr_d   = fetch_base_d;
                end else if (accept) begin
                    mem_en_d    = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = wr.i_wr_addr;
                    mem_wdata_d = wr.i_wr_data;
                    // Write wins the port this cycle; the fetch follows next cycle
                    if (trig) begin
                        pend_d       = 1'b1;
                        fetch_base_d = base_d;
                        fetch_bank_d = row_d[0];
                    end
                end
            end
            st_fetch: begin
                if (trig) overrun_d = 1'b1;
                if (idx_q == idx_w'(p_src_width - 1)) begin
                    state_d = st_drain;
                end else begin
                    idx_d      = idx_nxt;
                    mem_en_d   = 1'b1;
                    mem_addr_d = fetch_base_q + aw'(idx_nxt);
                end
            end
            st_drain: begin
                if (trig) overrun_d = 1'b1;
                state_d = st_idle;
            end
            default: state_d = st_idle;
        endcase

        wr_ready_d = (state_d == st_idle) && !pend_d;
    end

    assign wr.o_wr_ready = wr_ready_q;
    assign o_mem_en      = mem_en_q;
    assign o_mem_we      = mem_we_q;
    assign o_mem_addr    = mem_addr_q;
    assign o_mem_wdata   = mem_wdata_q;
    assign o_lb_we       = lb_we_q;
    assign o_lb_addr     = lb_addr_q;
    assign o_lb_wdata    = i_mem_rdata;
    assign o_rd_bank     = rd_bank_q;
    assign o_overrun     = overrun_q;
endmodule

// File: doc/thermal_fb_scheduler.md
# thermal_fb_scheduler

Schedules a single-port thermal framebuffer (p_src_width × p_src_height sensor pixels) between two users: the display path and the sensor writer. The display path is paced by the VGA timing generator's line strobe and signed y position. Ahead of each display row band, the block fetches one source row into a ping-pong line buffer for integer-factor upscaling. Sensor writes get the memory port whenever no fetch is running.

## Interface
Parameters:
- p_src_width, 32: source pixels per row; also the number of reads per fetch.
- p_src_height, 24: source rows per frame.
- p_scale, 20: display lines per source row (32×20 = 640, 24×20 = 480).
- p_addr_width, 10: framebuffer address width; must satisfy 2^p_addr_width ≥ p_src_width·p_src_height.
- p_data_width, 16: pixel width.
- p_count_width, 16: width of the signed y position from the timing generator.

Ports:
- i_clk_pixel  in  1  pixel clock; the only clock.
- i_rst  in  1  reset; synchronous, active-high.
- i_line  in  1  one-cycle strobe at x = 0 of every line, blanking lines included.
- i_y_pos  in  p_count_width signed  current line; negative during vertical blanking, 0 is the first visible line.
- i_wr_valid  in  1  sensor write request.
- i_wr_addr  in  p_addr_width  sensor write address.
- i_wr_data  in  p_data_width  sensor write data.
- o_wr_ready  out  1  write accepted when i_wr_valid & o_wr_ready.
- o_mem_en  out  1  framebuffer port enable.
- o_mem_we  out  1  framebuffer write enable.
- o_mem_addr  out  p_addr_width  framebuffer address.
- o_mem_wdata  out  p_data_width  framebuffer write data.
- i_mem_rdata  in  p_data_width  read data, valid exactly 1 cycle after the cycle o_mem_en=1 & o_mem_we=0.
- o_lb_we  out  1  line buffer write strobe.
- o_lb_addr  out  $clog2(p_src_width)+1  {bank, index}.
- o_lb_wdata  out  p_data_width  line buffer data, equal to i_mem_rdata (combinational passthrough).
- o_rd_bank  out  1  bank the display must read for the current line.
- o_overrun  out  1  sticky; set when a fetch trigger arrives while a fetch is still running.

## Operation
State machine:
- IDLE: the only state in which o_wr_ready=1.
- FETCH: issues p_src_width reads, one per cycle, at indices 0..p_src_width-1.
- DRAIN: one cycle to catch the last read's data.
- Transitions: IDLE→FETCH on trigger; FETCH→DRAIN after index p_src_width-1 is issued; DRAIN→IDLE unconditionally.

Trigger (evaluated on i_line=1):
- y = -1: set row=0, sub=0, row base=0, and trigger a fetch of row 0 into bank 0.
- 0 ≤ y ≤ p_src_height·p_scale-2:
  - sub==p_scale-1: set sub=0, row++, row base += p_src_width, and trigger a fetch of the new row into bank row[0].
  - otherwise: sub++.
- Any other y: no counter change, no trigger.
- Each trigger fetches the row used by display line y+1.

Addressing and banks:
- o_mem_addr = row base + index. No multiplier; the base is accumulated as above.
- o_lb_addr = {row[0], index}.
- o_rd_bank = bank of the row displayed on the current line. It updates on the i_line at which the display line enters a new row band, so it always points at the bank filled during the previous line.

Writes:
- In IDLE, an accepted write drives o_mem_en=1, o_mem_we=1, and the registered addr/data on the next cycle.
- A write and a trigger in the same IDLE cycle: the write is accepted; the fetch starts the following cycle.

Overrun:
- A trigger in FETCH or DRAIN sets o_overrun and is dropped.
- The row/sub counters still advance.

## Timing
- Reset values: state IDLE, o_wr_ready=1, o_mem_en=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_lb_we=0, o_lb_addr=0, o_rd_bank=0, o_overrun=0, row=0, sub=0, row base=0.
- Memory outputs are registered.
- Fetch with a trigger at cycle T:
  - T+1..T+p_src_width: reads, o_wr_ready=0.
  - T+2..T+p_src_width+1: o_lb_we=1, one index per cycle, in order.
  - T+p_src_width+1: DRAIN.
  - T+p_src_width+2: IDLE, o_wr_ready=1.
- Fetch occupancy is p_src_width+2 cycles, which must be less than the line period.
- Write accepted at T: memory write at T+1, single cycle.
- Reset mid-fetch: return to IDLE immediately with all reset values; partial line buffer contents are undefined until the next y=-1 trigger.

## Test plan
- Reset, then i_line at y=-1 → reads at addr 0..31 on cycles T+1..T+32; o_lb_we at T+2..T+33 with o_lb_addr {0,0..31} and data matching memory.
- Lines y=-1..479 → 24 fetches total, issued at y=-1,19,39,…,459; row 23 base = 736; o_rd_bank toggles every 20 lines.
- i_wr_valid held high across a fetch → ready drops T+1..T+33; no write overlaps a read; no request is lost; addr/data appear 1 cycle after acceptance.
- Write and trigger in the same cycle → write at T+1, first read at T+2.
- i_line pulses 10 cycles apart → o_overrun=1 and stays 1; second fetch suppressed; cleared only by i_rst.
- i_rst asserted at fetch cycle 10 → next cycle o_mem_en=0, o_lb_we=0, o_wr_ready=1, o_rd_bank=0.
